// File: rtl/core_pkg.sv
// Shared core constants and the fetch FSM state encoding.
package core_pkg;
   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;

   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: program memory port, decode handshake, redirect and status.
interface instr_fetch_unit_if;
   import core_pkg::*;

   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_data;
   logic            id_ready;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            if_valid;
   logic [XLEN-1:0] if_inst;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_pc_plus4;
   logic            fetch_fault;
   logic [XLEN-1:0] fault_pc;
   logic [XLEN-1:0] fetch_count;

   modport master (
      output imem_addr, if_valid, if_inst, if_pc, if_pc_plus4,
             fetch_fault, fault_pc, fetch_count,
      input  imem_data, id_ready, redirect_valid, redirect_target
   );

   modport slave (
      input  imem_addr, if_valid, if_inst, if_pc, if_pc_plus4,
             fetch_fault, fault_pc, fetch_count,
      output imem_data, id_ready, redirect_valid, redirect_target
   );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise contents hold.
module if_id_reg #(
   parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] fetch_inst,
   input  logic [31:0] fetch_pc,
   output logic        valid,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);
   import core_pkg::*;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= 1'b0;
         inst     <= NOP_INST;
         pc       <= '0;
         pc_plus4 <= 32'(INST_BYTES);
      end else if (flush) begin
         valid <= 1'b0;
         inst  <= NOP_INST;
      end else if (load) begin
         valid    <= 1'b1;
         inst     <= fetch_inst;
         pc       <= fetch_pc;
         pc_plus4 <= fetch_pc + 32'(INST_BYTES);
      end
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, redirect/fault FSM and fetch counter feeding IF/ID.
//   state | meaning
//   RUN   | fetching sequentially, honouring stalls and redirects
//   FAULT | bad PC seen; fetch frozen until reset
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = core_pkg::RESET_PC,
   parameter int          IMEM_WORDS = 64,
   parameter logic [31:0] NOP_INST   = core_pkg::NOP_INST
) (
   input logic               clk,
   input logic               rst,
   instr_fetch_unit_if.master bus
);
   import core_pkg::*;

   localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * INST_BYTES);

   fetch_state_e state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic [31:0]  fault_addr, fault_addr_nxt;
   logic [31:0]  count, count_nxt;
   logic         load, flush, adv, target_bad;

   assign adv        = !bus.if_valid || bus.id_ready;
   assign target_bad = (bus.redirect_target[1:0] != 2'b00) ||
                       (bus.redirect_target >= IMEM_BYTES);

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      fault_addr_nxt = fault_addr;
      count_nxt      = count;
      load           = 1'b0;
      flush          = 1'b0;
      case (state)
         RUN: begin
            if (bus.redirect_valid) begin
               flush = 1'b1;
               if (target_bad) begin
                  state_nxt      = FAULT;
                  fault_addr_nxt = bus.redirect_target;
               end else begin
                  pc_nxt = bus.redirect_target;
               end
            end else if (pc >= IMEM_BYTES) begin
               // Sequential fetch ran off the end of program memory.
               state_nxt      = FAULT;
               fault_addr_nxt = pc;
               flush          = 1'b1;
            end else if (adv) begin
               load      = 1'b1;
               pc_nxt    = pc + 32'(INST_BYTES);
               count_nxt = count + 32'd1;
            end
         end
         FAULT: flush = 1'b1;
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         pc         <= RESET_PC;
         fault_addr <= '0;
         count      <= '0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         fault_addr <= fault_addr_nxt;
         count      <= count_nxt;
      end
   end

   assign bus.imem_addr   = pc;
   assign bus.fetch_fault = (state == FAULT);
   assign bus.fault_pc    = fault_addr;
   assign bus.fetch_count = count;

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .flush      (flush),
      .fetch_inst (bus.imem_data),
      .fetch_pc   (pc),
      .valid      (bus.if_valid),
      .inst       (bus.if_inst),
      .pc         (bus.if_pc),
      .pc_plus4   (bus.if_pc_plus4)
   );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed plan sequences then random traffic.
module tb_instr_fetch_unit;
   localparam int MEM_WORDS = 64;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(
      .RESET_PC   (32'h0),
      .IMEM_WORDS (MEM_WORDS),
      .NOP_INST   (NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] mem [MEM_WORDS];

   function automatic logic [31:0] mem_read(input logic [31:0] addr);
      if (addr < 32'(MEM_WORDS * 4)) return mem[addr[7:2]];
      return 32'h0;
   endfunction

   assign bus.imem_data = mem_read(bus.imem_addr);

   typedef struct {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] addr;
      logic        fault;
      logic [31:0] fpc;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model state: what the fetch stage should look like after each edge.
   logic [31:0] m_pc, m_fpc, m_cnt, m_inst, m_ipc, m_ipc4;
   logic        m_valid, m_fault;

   task automatic model_step(input logic r, input logic rdy, input logic rv,
                             input logic [31:0] tgt);
      if (r) begin
         m_pc = 0; m_fault = 0; m_fpc = 0; m_cnt = 0;
         m_valid = 0; m_inst = NOP; m_ipc = 0; m_ipc4 = 4;
      end else if (m_fault) begin
         m_valid = 0;
         m_inst  = NOP;
      end else if (rv) begin
         m_valid = 0;
         m_inst  = NOP;
         if ((tgt % 4 != 0) || (tgt >= MEM_WORDS * 4)) begin
            m_fault = 1;
            m_fpc   = tgt;
         end else begin
            m_pc = tgt;
         end
      end else if (m_pc >= MEM_WORDS * 4) begin
         m_fault = 1;
         m_fpc   = m_pc;
         m_valid = 0;
         m_inst  = NOP;
      end else if (!m_valid || rdy) begin
         m_inst  = mem_read(m_pc);
         m_ipc   = m_pc;
         m_ipc4  = m_pc + 4;
         m_valid = 1;
         m_pc    = m_pc + 4;
         m_cnt   = m_cnt + 1;
      end
   endtask

   task automatic step(input logic r, input logic rdy, input logic rv,
                       input logic [31:0] tgt);
      exp_t e;
      rst                 = r;
      bus.id_ready        = rdy;
      bus.redirect_valid  = rv;
      bus.redirect_target = tgt;
      model_step(r, rdy, rv, tgt);
      e.valid = m_valid; e.inst = m_inst; e.pc = m_ipc; e.pc4 = m_ipc4;
      e.addr  = m_pc;    e.fault = m_fault; e.fpc = m_fpc; e.cnt = m_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   bit vec_bad;
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
         vec_bad = 1;
      end
   endtask

   // Monitor: one expected snapshot is consumed after every clock edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vec_bad = 0;
         cmp("if_valid",    32'(bus.if_valid),    32'(e.valid));
         cmp("if_inst",     bus.if_inst,          e.inst);
         cmp("if_pc",       bus.if_pc,            e.pc);
         cmp("if_pc_plus4", bus.if_pc_plus4,      e.pc4);
         cmp("imem_addr",   bus.imem_addr,        e.addr);
         cmp("fetch_fault", 32'(bus.fetch_fault), 32'(e.fault));
         cmp("fault_pc",    bus.fault_pc,         e.fpc);
         cmp("fetch_count", bus.fetch_count,      e.cnt);
         vectors++;
         if (vec_bad) miscompares++;
      end
   end

   initial begin
      logic [31:0] tgt;
      int          kind;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
      mem[0]  = 32'hfd01_0113;
      mem[1]  = 32'h0281_2623;
      mem[10] = 32'h0030_0793;
      rst = 1'b1; bus.id_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
      m_pc = 0; m_fpc = 0; m_cnt = 0; m_inst = NOP; m_ipc = 0; m_ipc4 = 4;
      m_valid = 0; m_fault = 0;
      @(posedge clk);
      #2;

      // Reset, then two fetches with decode ready.
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      // Three stalled cycles, release, then redirect to 40 during a stall.
      repeat (3) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 32'd40);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      // Misaligned redirect faults; later pulses are ignored.
      step(0, 1, 1, 32'd42);
      step(0, 1, 0, 0);
      step(0, 0, 1, 32'd8);
      step(0, 1, 1, 32'd16);
      step(1, 0, 0, 0);
      // Walk off the end of memory from 248.
      step(0, 1, 0, 0);
      step(0, 1, 1, 32'd248);
      repeat (5) step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      // Reset in the middle of a stalled redirect.
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 1, 32'd40);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);

      for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
      for (int n = 0; n < 600; n++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1, 2, 3, 4: tgt = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
            5:             tgt = 32'($urandom_range(MEM_WORDS - 3, MEM_WORDS - 1)) * 4;
            6:             tgt = 32'($urandom_range(0, MEM_WORDS * 4 - 1)) | 32'd1;
            7:             tgt = 32'(MEM_WORDS * 4) + 32'($urandom_range(0, 3)) * 4;
            default:       tgt = $urandom;
         endcase
         step(($urandom_range(0, 39) == 0) || (m_fault && $urandom_range(0, 5) == 0),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 7) == 0,
              tgt);
      end

      repeat (3) @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
